// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared definitions for the RV32I hazard/forwarding controller:
// register index width and the Execute operand-mux select encodings.
package hazard_fwd_ctrl_pkg;
   localparam int REG_W = 5;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;
endpackage

// File: rtl/hazard_fwd_ctrl_fwd_sel.sv
// Per-operand forwarding select: Memory-stage result wins over Writeback,
// and x0 is never forwarded because it is hard-wired to zero.
module fwd_sel
   import hazard_fwd_ctrl_pkg::*;
#(
   parameter int W = REG_W
) (
   input  logic [W-1:0] rs,
   input  logic [W-1:0] rd_m,
   input  logic         reg_write_m,
   input  logic [W-1:0] rd_w,
   input  logic         reg_write_w,
   output logic [1:0]   sel
);

   always_comb begin
      sel = FWD_RF;
      if (reg_write_m && (rd_m == rs) && (rs != '0))
         sel = FWD_M;
      else if (reg_write_w && (rd_w == rs) && (rs != '0))
         sel = FWD_W;
   end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard controller for the 5-stage core: operand forwarding, load-use and
// branch handling, whole-pipeline freeze on memory wait, and a wait watchdog.
module hazard_fwd_ctrl #(
   parameter int REG_W   = hazard_fwd_ctrl_pkg::REG_W,
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] Rs1D,
   input  logic [REG_W-1:0] Rs2D,
   input  logic [REG_W-1:0] RdD,
   input  logic             RegWriteD,
   input  logic             IsLoadD,
   input  logic             PCSrcE,
   input  logic             MemReqM,
   input  logic             MemReadyM,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             StallW,
   output logic             FlushD,
   output logic             FlushE,
   output logic             MemErr
);

   logic [REG_W-1:0] rs1_e_reg, rs2_e_reg, rd_e_reg, rd_m_reg, rd_w_reg;
   logic             reg_write_e_reg, is_load_e_reg, reg_write_m_reg, reg_write_w_reg;
   logic [CNT_W-1:0] wait_cnt_reg;
   logic             mem_err_reg;
   logic             mem_stall, lw_stall;

   assign mem_stall = MemReqM & ~MemReadyM;
   assign lw_stall  = is_load_e_reg && (rd_e_reg != '0) &&
                      ((rd_e_reg == Rs1D) || (rd_e_reg == Rs2D));

   // A memory wait freezes every stage; flushes are suppressed so a pending
   // branch in E survives until the access completes.
   always_comb begin
      StallF = lw_stall;
      StallD = lw_stall;
      StallE = 1'b0;
      StallM = 1'b0;
      StallW = 1'b0;
      FlushD = PCSrcE;
      FlushE = lw_stall | PCSrcE;
      if (mem_stall) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         StallW = 1'b1;
         FlushD = 1'b0;
         FlushE = 1'b0;
      end
   end

   fwd_sel #(.W(REG_W)) u_fwd_a (
      .rs          (rs1_e_reg),
      .rd_m        (rd_m_reg),
      .reg_write_m (reg_write_m_reg),
      .rd_w        (rd_w_reg),
      .reg_write_w (reg_write_w_reg),
      .sel         (ForwardAE)
   );

   fwd_sel #(.W(REG_W)) u_fwd_b (
      .rs          (rs2_e_reg),
      .rd_m        (rd_m_reg),
      .reg_write_m (reg_write_m_reg),
      .rd_w        (rd_w_reg),
      .reg_write_w (reg_write_w_reg),
      .sel         (ForwardBE)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rs1_e_reg       <= '0;
         rs2_e_reg       <= '0;
         rd_e_reg        <= '0;
         reg_write_e_reg <= 1'b0;
         is_load_e_reg   <= 1'b0;
         rd_m_reg        <= '0;
         reg_write_m_reg <= 1'b0;
         rd_w_reg        <= '0;
         reg_write_w_reg <= 1'b0;
      end else if (!mem_stall) begin
         if (FlushE) begin
            rs1_e_reg       <= '0;
            rs2_e_reg       <= '0;
            rd_e_reg        <= '0;
            reg_write_e_reg <= 1'b0;
            is_load_e_reg   <= 1'b0;
         end else begin
            rs1_e_reg       <= Rs1D;
            rs2_e_reg       <= Rs2D;
            rd_e_reg        <= RdD;
            reg_write_e_reg <= RegWriteD;
            is_load_e_reg   <= IsLoadD;
         end
         rd_m_reg        <= rd_e_reg;
         reg_write_m_reg <= reg_write_e_reg;
         rd_w_reg        <= rd_m_reg;
         reg_write_w_reg <= reg_write_m_reg;
      end
   end

   // Counter saturates at TIMEOUT so a very long hang cannot wrap it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt_reg <= '0;
         mem_err_reg  <= 1'b0;
      end else if (mem_stall) begin
         if (wait_cnt_reg != CNT_W'(TIMEOUT))
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
         if (wait_cnt_reg == CNT_W'(TIMEOUT - 1))
            mem_err_reg <= 1'b1;
      end else begin
         wait_cnt_reg <= '0;
      end
   end

   assign MemErr = mem_err_reg;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed-vector bench for hazard_fwd_ctrl: forwarding, load-use, branch
// flush, memory-wait freeze and the watchdog, with hand-computed expectations.
module tb_hazard_fwd_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] Rs1D, Rs2D, RdD;
   logic       RegWriteD, IsLoadD, PCSrcE, MemReqM, MemReadyM;
   logic [1:0] ForwardAE, ForwardBE;
   logic       StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, MemErr;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   hazard_fwd_ctrl #(.REG_W(5), .TIMEOUT(4), .CNT_W(7)) dut (
      .clk(clk), .reset(reset),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
      .RegWriteD(RegWriteD), .IsLoadD(IsLoadD), .PCSrcE(PCSrcE),
      .MemReqM(MemReqM), .MemReadyM(MemReadyM),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
      .FlushD(FlushD), .FlushE(FlushE), .MemErr(MemErr)
   );

   // Control bundle order: StallF StallD StallE StallM StallW FlushD FlushE
   wire [6:0] ctl = {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic rw, input logic ld);
      Rs1D = rs1; Rs2D = rs2; RdD = rd; RegWriteD = rw; IsLoadD = ld;
      #1;
   endtask

   task automatic nop();
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      reset = 1'b1; PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
      nop();
      step();
      n_vec++;
      if ({ForwardAE, ForwardBE, ctl, MemErr} !== 12'b0) begin
         n_err++;
         $display("FAIL reset_outputs: got %b expected %b", {ForwardAE, ForwardBE, ctl, MemErr}, 12'b0);
      end
      #2 reset = 1'b0;
      step();
      $display("test_reset done");
   endtask

   task automatic test_fwd_m();
      drive(5'd0, 5'd0, 5'd5, 1'b1, 1'b0);   // add x5
      step();
      drive(5'd5, 5'd0, 5'd0, 1'b0, 1'b0);   // consumer of x5
      step();
      nop();
      n_vec++;
      if ({ForwardAE, ForwardBE} !== 4'b10_00) begin
         n_err++;
         $display("FAIL fwd_m: got A=%b B=%b expected A=10 B=00", ForwardAE, ForwardBE);
      end
      n_vec++;
      if (ctl !== 7'b0) begin
         n_err++;
         $display("FAIL fwd_m_ctl: got %b expected 0000000", ctl);
      end
      step();
      $display("test_fwd_m done");
   endtask

   task automatic test_fwd_w_priority_x0();
      drive(5'd0, 5'd0, 5'd5, 1'b1, 1'b0); step();
      drive(5'd0, 5'd0, 5'd5, 1'b1, 1'b0); step();
      drive(5'd5, 5'd5, 5'd0, 1'b0, 1'b0); step();
      n_vec++;
      if ({ForwardAE, ForwardBE} !== 4'b10_10) begin
         n_err++;
         $display("FAIL fwd_m_priority: got A=%b B=%b expected A=10 B=10", ForwardAE, ForwardBE);
      end
      drive(5'd0, 5'd0, 5'd5, 1'b1, 1'b0); step();
      nop();                                   step();
      drive(5'd5, 5'd5, 5'd0, 1'b0, 1'b0); step();
      n_vec++;
      if ({ForwardAE, ForwardBE} !== 4'b01_01) begin
         n_err++;
         $display("FAIL fwd_w_only: got A=%b B=%b expected A=01 B=01", ForwardAE, ForwardBE);
      end
      drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0); step();   // write to x0
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0); step();
      n_vec++;
      if ({ForwardAE, ForwardBE} !== 4'b00_00) begin
         n_err++;
         $display("FAIL fwd_x0: got A=%b B=%b expected A=00 B=00", ForwardAE, ForwardBE);
      end
      nop(); step(); step(); step();
      $display("test_fwd_w_priority_x0 done");
   endtask

   task automatic test_load_use();
      drive(5'd0, 5'd0, 5'd7, 1'b1, 1'b1);   // lw x7
      step();
      drive(5'd0, 5'd7, 5'd0, 1'b0, 1'b0);   // uses x7 as rs2
      n_vec++;
      if (ctl !== 7'b1100001) begin
         n_err++;
         $display("FAIL load_use_stall: got %b expected 1100001", ctl);
      end
      step();
      n_vec++;
      if (ctl !== 7'b0) begin
         n_err++;
         $display("FAIL load_use_one_cycle: got %b expected 0000000", ctl);
      end
      step();
      nop();
      n_vec++;
      if ({ForwardAE, ForwardBE} !== 4'b00_01) begin
         n_err++;
         $display("FAIL load_use_fwd: got A=%b B=%b expected A=00 B=01", ForwardAE, ForwardBE);
      end
      step(); step(); step();
      $display("test_load_use done");
   endtask

   task automatic test_branch();
      drive(5'd0, 5'd0, 5'd9, 1'b1, 1'b0); step();   // add x9 into E
      drive(5'd0, 5'd0, 5'd3, 1'b1, 1'b0);           // wrong-path write x3
      PCSrcE = 1'b1; #1;
      n_vec++;
      if (ctl !== 7'b0000011) begin
         n_err++;
         $display("FAIL branch_flush: got %b expected 0000011", ctl);
      end
      step();
      PCSrcE = 1'b0;
      drive(5'd9, 5'd3, 5'd0, 1'b0, 1'b0);
      step();
      nop();
      n_vec++;
      if ({ForwardAE, ForwardBE} !== 4'b01_00) begin
         n_err++;
         $display("FAIL branch_rde_cleared: got A=%b B=%b expected A=01 B=00", ForwardAE, ForwardBE);
      end
      step(); step(); step();
      $display("test_branch done");
   endtask

   task automatic test_mem_wait();
      drive(5'd0, 5'd0, 5'd4, 1'b1, 1'b0); step();
      drive(5'd4, 5'd0, 5'd6, 1'b1, 1'b0); step();
      MemReqM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1;
      nop();
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if ({ctl, ForwardAE, MemErr} !== 10'b1111100_10_0) begin
            n_err++;
            $display("FAIL mem_wait_cycle%0d: got ctl=%b A=%b err=%b expected ctl=1111100 A=10 err=0",
                     i, ctl, ForwardAE, MemErr);
         end
         step();
      end
      MemReadyM = 1'b1; #1;
      n_vec++;
      if ({ctl, ForwardAE, MemErr} !== 10'b0000011_10_0) begin
         n_err++;
         $display("FAIL mem_ready_flush: got ctl=%b A=%b err=%b expected ctl=0000011 A=10 err=0",
                  ctl, ForwardAE, MemErr);
      end
      step();
      MemReqM = 1'b0; MemReadyM = 1'b0; PCSrcE = 1'b0; #1;
      n_vec++;
      if ({ForwardAE, ctl} !== 9'b00_0000000) begin
         n_err++;
         $display("FAIL mem_resume: got A=%b ctl=%b expected A=00 ctl=0000000", ForwardAE, ctl);
      end
      step(); step(); step();
      $display("test_mem_wait done");
   endtask

   task automatic test_watchdog();
      MemReqM = 1'b1; MemReadyM = 1'b0; #1;
      for (int i = 1; i <= 4; i++) begin
         step();
         n_vec++;
         if (MemErr !== (i == 4)) begin
            n_err++;
            $display("FAIL watchdog_edge%0d: got MemErr=%b expected %b", i, MemErr, (i == 4));
         end
      end
      MemReadyM = 1'b1; step();
      MemReqM = 1'b0; MemReadyM = 1'b0; step();
      n_vec++;
      if (MemErr !== 1'b1) begin
         n_err++;
         $display("FAIL watchdog_sticky: got MemErr=%b expected 1", MemErr);
      end
      #2 reset = 1'b1; #1;
      n_vec++;
      if ({MemErr, ForwardAE, ForwardBE, ctl} !== 12'b0) begin
         n_err++;
         $display("FAIL watchdog_async_reset: got %b expected 000000000000",
                  {MemErr, ForwardAE, ForwardBE, ctl});
      end
      step();
      reset = 1'b0;
      step();
      $display("test_watchdog done");
   endtask

   initial begin
      test_reset();
      test_fwd_m();
      test_fwd_w_priority_x0();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_watchdog();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I core; generates the 2-bit operand-forwarding selects consumed by the Execute-stage 3:1 operand muxes, plus all stall and flush controls.
- Keeps its own shadow copy of register-destination metadata for the E/M/W stages, honouring its own stall and flush outputs.
- Freezes the whole pipeline while a Memory-stage data access waits on a ready handshake; a watchdog flags hung accesses.

Parameters:
- REG_W, 5, register index width.
- TIMEOUT, 64, consecutive memory-wait cycles before MemErr is raised (must be ≥1).
- CNT_W, 7, watchdog counter width (must satisfy 2^CNT_W > TIMEOUT).

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- Rs1D  input  REG_W  Decode source register 1.
- Rs2D  input  REG_W  Decode source register 2.
- RdD  input  REG_W  Decode destination register.
- RegWriteD  input  1  Decode instruction writes the register file.
- IsLoadD  input  1  Decode instruction is a load (ResultSrc = memory).
- PCSrcE  input  1  taken branch or jump resolved in Execute.
- MemReqM  input  1  Memory-stage instruction performs a data access.
- MemReadyM  input  1  data memory completes the access this cycle.
- ForwardAE  output  2  operand A select: 00 regfile, 01 ResultW, 10 ALUResultM.
- ForwardBE  output  2  operand B select, same encoding.
- StallF, StallD, StallE, StallM, StallW  output  1 each  hold the corresponding pipeline register.
- FlushD, FlushE  output  1 each  clear the corresponding pipeline register.
- MemErr  output  1  sticky watchdog error.

Behaviour:
- Shadow registers: E stage holds Rs1E, Rs2E, RdE, RegWriteE, IsLoadE. M stage holds RdM, RegWriteM. W stage holds RdW, RegWriteW. All are 0 after reset.
- memStall = MemReqM & ~MemReadyM.
- Forwarding (combinational from shadow regs), per operand with source Rs in {Rs1E, Rs2E}:
  - 10 if RegWriteM & RdM == Rs & Rs != 0.
  - else 01 if RegWriteW & RdW == Rs & Rs != 0.
  - else 00.
  - M has priority over W. x0 is never forwarded. Value 11 is never driven.
- lwStall = IsLoadE & (RdE != 0) & (RdE == Rs1D | RdE == Rs2D).
- When memStall = 1:
  - All five Stall outputs = 1; FlushD = FlushE = 0; all shadow registers hold.
  - A simultaneous PCSrcE is deferred: it stays asserted because E is held.
- When memStall = 0:
  - StallF = StallD = lwStall; StallE = StallM = StallW = 0.
  - FlushD = PCSrcE; FlushE = lwStall | PCSrcE.
  - Shadow E: cleared if FlushE, else loaded from the D inputs.
  - Shadow M loads from E; shadow W loads from M.
- Watchdog:
  - waitCnt increments each memStall cycle and clears to 0 on any non-stall cycle.
  - When waitCnt reaches TIMEOUT, MemErr sets on that edge.
  - MemErr is sticky until reset. The stall is not released by MemErr.
- Reset mid-operation: asynchronous; outputs settle to the no-hazard values (Forward = 00, stalls/flushes = 0 unless driven by current inputs) in the same cycle; MemErr = 0.
- Latency: all outputs are combinational from the current inputs and shadow state. Shadow state updates on the rising edge.

Decomposition:
- Shared package: forwarding-select constants FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10, plus REG_W.
- One natural sub-module, fwd_sel: combinational per-operand select generator, instantiated twice (operands A and B).

Test Plan:
- Forward from M: D issues add x5 (RegWriteD = 1, RdD = 5), next cycle Rs1D = 5. → In the following cycle ForwardAE = 10, ForwardBE = 00.
- Forward from W, M priority, and x0:
  - x5 written in W and M simultaneously → 10.
  - x5 written only in W → 01.
  - Rd = 0 with RegWrite = 1 → 00.
- Load-use: lw x7 in E (IsLoadD the previous cycle), Rs2D = 7.
  - → StallF = StallD = FlushE = 1 for exactly one cycle.
  - Next cycle ForwardBE = 01 (the load result is now in W after the bubble via M).
- Branch: PCSrcE = 1 with no memStall → FlushD = FlushE = 1 and shadow RdE clears to 0 next edge.
- Memory wait: MemReqM = 1, MemReadyM = 0 for 3 cycles, PCSrcE = 1 throughout.
  - → All Stall outputs = 1 and flushes = 0 for 3 cycles; shadow state unchanged.
  - On the cycle MemReadyM = 1: FlushD = FlushE = 1.
- Watchdog (TIMEOUT = 4): MemReadyM held low 4 cycles → MemErr = 1 after the 4th edge and stays 1 after MemReadyM rises. Asserting reset clears it to 0 immediately.
